ram8x4_loader: RTL

Write-side companion to the 8x4 lookup memory. It holds an 8-entry x 4-bit RAM and fills it from a valid/ready word stream, starting at a programmable base address, with wrap-around. It also offers a sequenced bulk-clear. An asynchronous combinational read port (addr in, data out) lets downstream logic read the RAM the same way it reads the fixed ROM.

---
 rtl/ram8x4_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ram8x4_loader.sv
// 8x4 RAM filled from a valid/ready word stream with wrap-around,
// plus a sequenced bulk clear and a combinational read port.
module ram8x4_loader #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      load_len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      wr_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CLEAR,
        DONE
    } state_t;

    localparam logic [AW:0]   FULL = AW'(0) + (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    state_t           nstate;
    logic [AW-1:0]    ptr;
    logic [AW:0]      len;
    logic [AW:0]      eff_len;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             hs;

    // Zero or oversize lengths mean a full-memory burst.
    assign eff_len = (load_len == '0 || load_len > FULL) ? FULL : load_len;
    assign hs      = in_valid && in_ready;
    assign rd_data = mem[rd_addr];

    always_comb begin
        nstate   = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (clear) begin
                    nstate = CLEAR;
                end else if (start) begin
                    nstate = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && (wr_count + 1'b1) == len) begin
                    nstate = DONE;
                end
            end
            CLEAR: begin
                busy = 1'b1;
                if (ptr == LAST) begin
                    nstate = DONE;
                end
            end
            DONE: begin
                done   = 1'b1;
                nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            len      <= '0;
            wr_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= nstate;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        ptr      <= '0;
                        wr_count <= '0;
                    end else if (start) begin
                        ptr      <= base_addr;
                        len      <= eff_len;
                        wr_count <= '0;
                    end
                end
                LOAD: begin
                    if (hs) begin
                        mem[ptr] <= in_data;
                        ptr      <= ptr + 1'b1;
                        wr_count <= wr_count + 1'b1;
                    end
                end
                CLEAR: begin
                    mem[ptr] <= '0;
                    ptr      <= ptr + 1'b1;
                    wr_count <= wr_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
